// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronizes and debounces an active-low raw button,
// then classifies each press into single-cycle press / short / long command pulses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int CNT_W             = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    typedef struct packed {
        logic press;
        logic short_p;
        logic long_p;
    } evt_t;

    logic [1:0]       sync_q, sync_d;
    logic             sync_now;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             pressed_q, pressed_d;
    logic             stable_rise, stable_fall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    evt_t             evt_q, evt_d;

    // sync_q holds raw pin levels, so its reset value 2'b11 means released
    always_comb begin
        sync_d   = {sync_q[0], btn_n};
        sync_now = ~sync_q[1];
    end

    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync_now != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d  = sync_now;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // pressed_q lags stable_q by one cycle, which doubles as the edge detector
    always_comb begin
        pressed_d   = stable_q;
        stable_rise = stable_q & ~pressed_q;
        stable_fall = ~stable_q & pressed_q;
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        evt_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (stable_rise) begin
                    state_d    = PRESSED;
                    hold_cnt_d = '0;
                    evt_d.press = 1'b1;
                end
            end
            PRESSED: begin
                if (stable_fall) begin
                    state_d       = IDLE;
                    evt_d.short_p = 1'b1;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = LONG_HELD;
                    evt_d.long_p = 1'b1;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG_HELD: begin
                if (stable_fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= 2'b11;
            stable_q   <= 1'b0;
            deb_cnt_q  <= '0;
            pressed_q  <= 1'b0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            evt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            stable_q   <= stable_d;
            deb_cnt_q  <= deb_cnt_d;
            pressed_q  <= pressed_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            evt_q      <= evt_d;
        end
    end

    assign pressed     = pressed_q;
    assign press_pulse = evt_q.press;
    assign short_pulse = evt_q.short_p;
    assign long_pulse  = evt_q.long_p;

    a_pulse_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(evt_q));
    a_long_state:   assert property (@(posedge clk) disable iff (!reset) evt_q.long_p |-> state_q == LONG_HELD);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: stimulus queues expected output events
// with their cycle numbers; an independent monitor pops and compares them.
module tb_button_conditioner;

    localparam int DEB   = 4;
    localparam int LONGC = 20;
    localparam int LAT   = 2 + DEB;

    localparam int K_RISE  = 0;
    localparam int K_PRESS = 1;
    localparam int K_FALL  = 2;
    localparam int K_SHORT = 3;
    localparam int K_LONG  = 4;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    logic clk;
    logic reset;
    logic btn_n;
    logic pressed, press_pulse, short_pulse, long_pulse;

    int   cyc;
    int   checks;
    int   fails;
    exp_t q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONGC),
        .CNT_W            (26)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .pressed    (pressed),
        .press_pulse(press_pulse),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_RISE:  return "pressed_rise";
            K_PRESS: return "press_pulse";
            K_FALL:  return "pressed_fall";
            K_SHORT: return "short_pulse";
            K_LONG:  return "long_pulse";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int k, input int c);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        q.push_back(e);
    endtask

    task automatic got(input int k);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", kname(k), cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                fails++;
                $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                         kname(k), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: samples on the falling edge, well away from the active edge
    initial begin
        logic prev;
        int   n;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 1'b0;
            end else begin
                n = int'(press_pulse) + int'(short_pulse) + int'(long_pulse);
                if (n > 0) begin
                    checks++;
                    if (n > 1) begin
                        fails++;
                        $display("FAIL pulse_onehot: got %0d pulses at cycle %0d, required at most 1", n, cyc);
                    end
                end
                if (pressed && !prev) got(K_RISE);
                if (press_pulse)      got(K_PRESS);
                if (!pressed && prev) got(K_FALL);
                if (short_pulse)      got(K_SHORT);
                if (long_pulse)       got(K_LONG);
                prev = pressed;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic chk_idle(input string name);
        logic [3:0] v;
        v = {pressed, press_pulse, short_pulse, long_pulse};
        checks++;
        if (v !== 4'b0000) begin
            fails++;
            $display("FAIL %s: got outputs %b, required 0000", name, v);
        end
    endtask

    // Hold btn_n low for `hold` cycles; `is_long` says whether long_pulse is due
    task automatic do_press(input int hold, input bit is_long);
        int t0, tr;
        t0    = cyc + 1;
        btn_n = 1'b0;
        push(K_RISE, t0 + LAT);
        push(K_PRESS, t0 + LAT);
        if (is_long) push(K_LONG, t0 + LAT + LONGC);
        repeat (hold) step();
        tr    = cyc + 1;
        btn_n = 1'b1;
        push(K_FALL, tr + LAT);
        if (!is_long) push(K_SHORT, tr + LAT);
    endtask

    initial begin
        int t0, tr;
        checks = 0;
        fails  = 0;
        reset  = 1'b0;
        btn_n  = 1'b1;

        // Reset held while the pin toggles
        for (int i = 0; i < 8; i++) begin
            step();
            btn_n = i[0];
            chk_idle("reset_hold");
        end
        btn_n = 1'b1;
        step();
        reset = 1'b1;
        repeat (30) step();
        chk_idle("post_reset_idle");

        // Clean short press
        do_press(10, 1'b0);
        repeat (12) step();

        // Bounce then settle low
        for (int i = 0; i < 6; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) step();
        end
        do_press(10, 1'b0);
        repeat (12) step();

        // Glitch one cycle shorter than the debounce window
        btn_n = 1'b0;
        repeat (DEB - 1) step();
        btn_n = 1'b1;
        repeat (15) step();
        chk_idle("glitch_no_change");

        // Long press
        do_press(40, 1'b1);
        repeat (12) step();

        // Release lands on the same cycle as the long threshold: release wins
        do_press(20, 1'b0);
        repeat (12) step();

        // One cycle longer: long fires, no short
        do_press(21, 1'b1);
        repeat (12) step();

        // Reset in the middle of a held press
        t0    = cyc + 1;
        btn_n = 1'b0;
        push(K_RISE, t0 + LAT);
        push(K_PRESS, t0 + LAT);
        repeat (16) step();
        reset = 1'b0;
        #1;
        chk_idle("reset_midpress");
        repeat (3) step();
        reset = 1'b1;
        t0    = cyc + 1;
        push(K_RISE, t0 + LAT);
        push(K_PRESS, t0 + LAT);
        repeat (15) step();
        tr    = cyc + 1;
        btn_n = 1'b1;
        push(K_FALL, tr + LAT);
        push(K_SHORT, tr + LAT);
        repeat (12) step();

        // Back-to-back presses
        do_press(10, 1'b0);
        repeat (8) step();
        do_press(10, 1'b0);
        repeat (15) step();

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            fails++;
            $display("FAIL missing_event: got nothing, required %s at cycle %0d", kname(e.kind), e.cyc);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
